vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Downstream consumer of the frame-buffer read stage. Buffers the
//  RGB_in/X_in/Y_in pixel stream in a small FIFO using a valid/ready
//  handshake. Generates VGA 640x480 timing and drives registered 5:5:5
//  colour out of the FIFO during the active video region.
//  Detects and recovers from FIFO underflow and frame misalignment.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (clocks)
//  H_SYNC      96   hsync pulse width (clocks)
//  H_BP        48   horizontal back porch (clocks)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync pulse width (lines)
//  V_BP        33   vertical back porch (lines)
//  FIFO_DEPTH  16   pixel FIFO entries; power of 2, >= 4
//  FILL_LEVEL  8    entries required before scan-out starts; 1..FIFO_DEPTH
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   async reset, active-low (asserted when 0)
//  pix_valid  in   1   RGB_in/X_in/Y_in hold a valid pixel
//  pix_ready  out  1   FIFO can accept; transfer = pix_valid & pix_ready
//  RGB_in     in   15  pixel colour {R[14:10],G[9:5],B[4:0]}
//  X_in       in   10  pixel column
//  Y_in       in   10  pixel row
//  hsync      out  1   horizontal sync, active-low
//  vsync      out  1   vertical sync, active-low
//  active     out  1   R/G/B carry a visible pixel
//  R,G,B      out  5   colour outputs; 0 outside the active region
//  underflow  out  1   sticky: active cycle found FIFO empty
//  sync_err   out  1   sticky: FIFO head disagreed with raster position
// BEHAVIOUR
//  Reset (rst=0, async): FSM=FILL; FIFO empty; hcnt=vcnt=0.
//    Outputs on reset: hsync=vsync=1, active=0, RGB=0,
//    underflow=sync_err=0, pix_ready=0.
//  FIFO entry = {sof, RGB_in}; sof = (X_in==0 && Y_in==0).
//    pix_ready = !full, registered; deassertion does not depend on a
//    same-cycle pop. No write-to-read bypass.
//  FSM FILL:
//    hcnt/vcnt held at 0; sync/active outputs idle.
//    Transfer with sof=0 while FIFO empty: accepted, discarded.
//      This guarantees the FIFO head is always a sof pixel.
//    Go to RUN on the cycle after count >= FILL_LEVEL.
//  FSM RUN:
//    hcnt counts 0..H_TOTAL-1, then wraps.
//      H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
//    vcnt increments on hcnt wrap, counts 0..V_TOTAL-1 (525), then wraps.
//    vis = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
//    hs_n = 0 for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//    vs_n = 0 for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
//    Each vis cycle pops exactly one entry.
//    Outputs registered, 1 clock after counters; hsync, vsync, active and
//    RGB stay mutually aligned.
//    Pop while FIFO empty: RGB=0, underflow<=1, err flag set.
//    Popped sof !=(hcnt==0 && vcnt==0): sync_err<=1, err flag set.
//      Bad pixel is still displayed.
//    At end of frame (hcnt=799, vcnt=524) with err flag set: go to RESYNC.
//      Otherwise continue to the next frame.
//  FSM RESYNC (1 cycle):
//    Flush FIFO, clear err flag, zero counters, go to FILL.
//    Sticky outputs are NOT cleared.
//  underflow/sync_err clear only on reset.
//  Mid-operation reset: everything returns to reset values immediately.
//    Upstream must restart from pixel (0,0).
// TESTING
//  1. Reset, stream (0,0),(1,0).. continuously -> RUN after 8 pushes.
//     First active=1 shows RGB of (0,0). hsync low at output clocks
//     657..752 of each line; vsync low on lines 490..491.
//  2. Full frame, RGB_in=X_in[4:0] -> R/G/B match per pixel.
//     Exactly 307200 active cycles per frame. Frame 2 also matches.
//     underflow=0, sync_err=0.
//  3. Stall pix_valid for 20 cycles mid-line in RUN -> underflow=1, black
//     pixels output. At frame end FSM goes RESYNC->FILL; pix_ready drops
//     when full.
//  4. In FILL, send (5,3),(6,3) then (0,0) -> first two discarded.
//     FIFO count=1 after (0,0).
//  5. Hold pix_valid=1 with FIFO full -> pix_ready=0; no entry
//     overwritten; RGB order preserved after drain.
//  6. Assert rst=0 mid-line -> outputs return to reset values in the same
//     cycle (async). pix_ready=0 until reset is released.

Source files
------------

// File: rtl/vga_scanout.sv
`default_nettype none
// =============================================================================
// vga_scanout : pixel FIFO feeding VGA raster timing with registered 5:5:5
//               colour, underflow/alignment detection and self-resync. Rev 1.0
// =============================================================================
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16,
  parameter int FILL_LEVEL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [14:0] RGB_in,
  input  logic [9:0]  X_in,
  input  logic [9:0]  Y_in,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [4:0]  R,
  output logic [4:0]  G,
  output logic [4:0]  B,
  output logic        underflow,
  output logic        sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d;
  logic          uf_q, uf_d, se_q, se_d;
  logic [14:0]   rgb_q, rgb_d;

  logic          w_xfer, w_sof, w_empty, w_run, w_vis, w_pop, w_uf, w_se;
  logic          w_push, w_h_last, w_v_last, w_origin;
  logic [AW:0]   w_count;
  logic [15:0]   w_head;
  logic [31:0]   w_h, w_v;

  assign w_h      = 32'(hcnt_q);
  assign w_v      = 32'(vcnt_q);
  assign w_count  = wr_q - rd_q;
  assign w_empty  = (w_count == '0);
  assign w_xfer   = pix_valid & ready_q;
  assign w_sof    = (X_in == 10'd0) && (Y_in == 10'd0);
  assign w_run    = (state_q == ST_RUN);
  assign w_vis    = w_run && (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign w_pop    = w_vis && !w_empty;
  assign w_uf     = w_vis && w_empty;
  assign w_head   = mem_q[rd_q[AW-1:0]];
  assign w_origin = (hcnt_q == '0) && (vcnt_q == '0);
  assign w_se     = w_pop && (w_head[15] != w_origin);
  assign w_h_last = (w_h == H_TOTAL - 1);
  assign w_v_last = (w_v == V_TOTAL - 1);

  // While filling, an orphan non-sof pixel into an empty FIFO is dropped so the
  // head of the FIFO is always the start of a frame.
  assign w_push = w_xfer && (state_q != ST_RESYNC) &&
                  !((state_q == ST_FILL) && w_empty && !w_sof);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    wr_d    = wr_q + {{AW{1'b0}}, w_push};
    rd_d    = rd_q + {{AW{1'b0}}, w_pop};
    err_d   = err_q | w_uf | w_se;
    // Conservative: ignores a same-cycle pop so the next push is always safe.
    ready_d = (32'(w_count) + 32'(w_push)) < FIFO_DEPTH;

    case (state_q)
      ST_FILL: begin
        if (32'(w_count) >= FILL_LEVEL) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_h_last) begin
          hcnt_d = '0;
          if (w_v_last) begin
            vcnt_d = '0;
            if (err_q) begin
              state_d = ST_RESYNC;
            end
          end else begin
            vcnt_d = vcnt_q + VW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      ST_RESYNC: begin
        wr_d    = '0;
        rd_d    = '0;
        err_d   = 1'b0;
        hcnt_d  = '0;
        vcnt_d  = '0;
        ready_d = 1'b1;
        state_d = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_comb begin
    hs_d  = !(w_run && (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC));
    vs_d  = !(w_run && (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC));
    act_d = w_vis;
    rgb_d = w_pop ? w_head[14:0] : 15'd0;
    uf_d  = uf_q | w_uf;
    se_d  = se_q | w_se;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      act_q   <= 1'b0;
      rgb_q   <= '0;
      uf_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      act_q   <= act_d;
      rgb_q   <= rgb_d;
      uf_q    <= uf_d;
      se_q    <= se_d;
    end
  end

  // Storage needs no reset: pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_q[AW-1:0]] <= {w_sof, RGB_in};
    end
  end

  assign pix_ready = ready_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign active    = act_q;
  assign R         = rgb_q[14:10];
  assign G         = rgb_q[9:5];
  assign B         = rgb_q[4:0];
  assign underflow = uf_q;
  assign sync_err  = se_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// =============================================================================
// tb_vga_scanout : scoreboard bench for vga_scanout on a reduced raster. Rev 1.0
// =============================================================================
module tb_vga_scanout;

  localparam int HA = 16, HF = 4, HS = 4, HB = 8;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int DEPTH = 16, FILL = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [14:0] RGB_in = '0;
  logic [9:0]  X_in = '0, Y_in = '0;
  logic        hsync, vsync, active, underflow, sync_err;
  logic [4:0]  R, G, B;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(DEPTH), .FILL_LEVEL(FILL)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .RGB_in(RGB_in), .X_in(X_in), .Y_in(Y_in),
    .hsync(hsync), .vsync(vsync), .active(active),
    .R(R), .G(G), .B(B), .underflow(underflow), .sync_err(sync_err)
  );

  typedef struct packed {
    logic        rdy;
    logic        hs;
    logic        vs;
    logic        act;
    logic [14:0] rgb;
    logic        uf;
    logic        se;
  } obs_t;

  typedef enum {M_FILL, M_RUN, M_RESYNC} mst_t;

  obs_t        exp_q[$];
  int          total = 0;
  int          bad = 0;

  // Reference model: FIFO as a queue, raster as a linear frame position.
  mst_t        m_st;
  logic [15:0] m_fifo[$];
  int          m_pos;
  bit          m_err;
  obs_t        m_out;

  // Upstream pixel source walking the visible area in raster order.
  int          up_x, up_y;
  logic [14:0] up_rgb;
  bit          pattern = 1'b1;

  function automatic obs_t reset_obs();
    obs_t o;
    o.rdy = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.act = 1'b0;
    o.rgb = '0;   o.uf = 1'b0; o.se = 1'b0;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t a;
    a.rdy = pix_ready; a.hs = hsync; a.vs = vsync; a.act = active;
    a.rgb = {R, G, B}; a.uf = underflow; a.se = sync_err;
    return a;
  endfunction

  function automatic logic [14:0] pick_rgb(input int x);
    logic [9:0] xv;
    xv = x[9:0];
    if (pattern) return {xv[4:0], xv[4:0], xv[4:0]};
    return 15'($urandom);
  endfunction

  task automatic model_reset();
    m_st = M_FILL;
    m_fifo.delete();
    m_pos = 0;
    m_err = 1'b0;
    m_out = reset_obs();
    up_x = 0;
    up_y = 0;
    up_rgb = pick_rgb(0);
  endtask

  task automatic model_step(input bit v);
    bit          xfer, sof, pushed;
    int          pre, h, ln;
    obs_t        o;
    logic [15:0] e;
    xfer   = v && m_out.rdy;
    pre    = m_fifo.size();
    sof    = (up_x == 0) && (up_y == 0);
    pushed = 1'b0;
    o = m_out;
    o.hs = 1'b1; o.vs = 1'b1; o.act = 1'b0; o.rgb = '0;
    if (m_st == M_RUN) begin
      h  = m_pos % HT;
      ln = m_pos / HT;
      o.hs = !(h >= HA + HF && h < HA + HF + HS);
      o.vs = !(ln >= VA + VF && ln < VA + VF + VS);
      if (h < HA && ln < VA) begin
        o.act = 1'b1;
        if (pre == 0) begin
          o.uf = 1'b1;
          m_err = 1'b1;
        end else begin
          e = m_fifo.pop_front();
          o.rgb = e[14:0];
          if (e[15] != (m_pos == 0)) begin
            o.se = 1'b1;
            m_err = 1'b1;
          end
        end
      end
    end
    if (xfer) begin
      if (m_st != M_RESYNC && !(m_st == M_FILL && pre == 0 && !sof)) begin
        m_fifo.push_back({sof, up_rgb});
        pushed = 1'b1;
      end
      up_x++;
      if (up_x == HA) begin
        up_x = 0;
        up_y = (up_y + 1) % VA;
      end
      up_rgb = pick_rgb(up_x);
    end
    o.rdy = (pre + int'(pushed)) < DEPTH;
    case (m_st)
      M_FILL: if (pre >= FILL) begin m_st = M_RUN; m_pos = 0; end
      M_RUN: begin
        if (m_pos == FRAME - 1) begin
          m_pos = 0;
          if (m_err) m_st = M_RESYNC;
        end else begin
          m_pos++;
        end
      end
      default: begin
        m_fifo.delete();
        m_err = 1'b0;
        m_pos = 0;
        o.rdy = 1'b1;
        m_st  = M_FILL;
      end
    endcase
    m_out = o;
  endtask

  task automatic cycle(input bit v, input bit rst_v);
    @(posedge clk);
    #1;
    rst = rst_v;
    if (!rst_v) model_reset();
    pix_valid = v;
    X_in = up_x[9:0];
    Y_in = up_y[9:0];
    RGB_in = up_rgb;
    exp_q.push_back(m_out);
    if (rst_v) model_step(v);
  endtask

  task automatic wait_pos(input int target, input int budget);
    int n;
    n = 0;
    while (!(m_st == M_RUN && m_pos == target) && n < budget) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL wait_pos: raster position %0d not reached within %0d cycles", target, budget);
    end
  endtask

  task automatic async_reset_check();
    obs_t a;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    a = observe();
    total++;
    if (a !== reset_obs()) begin
      bad++;
      $display("FAIL async_reset: got=%h want=%h", a, reset_obs());
    end
    model_reset();
    exp_q.push_back(m_out);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = observe();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL scan t=%0t got rdy=%b hs=%b vs=%b act=%b rgb=%h uf=%b se=%b want rdy=%b hs=%b vs=%b act=%b rgb=%h uf=%b se=%b",
                   $time, a.rdy, a.hs, a.vs, a.act, a.rgb, a.uf, a.se,
                   e.rdy, e.hs, e.vs, e.act, e.rgb, e.uf, e.se);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    repeat (3) cycle(1'b0, 1'b0);

    // Orphan pixels before the frame origin are dropped while filling.
    cycle(1'b0, 1'b1);
    up_x = 5; up_y = 3; up_rgb = pick_rgb(5);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    up_x = 0; up_y = 0; up_rgb = pick_rgb(0);
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);

    // Continuous stream with X-derived colour: fill, then several clean frames.
    repeat (3 * FRAME + 50) cycle(1'b1, 1'b1);
    check_bit("underflow_clean", underflow, 1'b0);
    check_bit("sync_err_clean", sync_err, 1'b0);

    // Random colour and random valid gaps.
    pattern = 1'b0;
    repeat (2 * FRAME) cycle($urandom_range(0, 7) != 0, 1'b1);

    // Long stall from the start of a visible line forces underflow and resync.
    wait_pos(HT, 3 * FRAME);
    repeat (40) cycle(1'b0, 1'b1);
    repeat (3 * FRAME) cycle(1'b1, 1'b1);
    check_bit("underflow_sticky", underflow, 1'b1);

    // Asynchronous reset in the middle of a visible line.
    wait_pos(2 * HT + 5, 3 * FRAME);
    async_reset_check();
    repeat (3) cycle(1'b1, 1'b0);
    check_bit("ready_in_reset", pix_ready, 1'b0);
    repeat (FRAME + 100) cycle($urandom_range(0, 3) != 0, 1'b1);
    check_bit("underflow_after_reset", underflow, m_out.uf);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
